// File: rtl/alu_md.sv
// Single-issue integer ALU with iterative multiply/divide.
// Base ops finish one cycle after acceptance; MUL*/DIV*/REM* iterate XLEN cycles.
module alu_md #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            zero,
    output logic            carry,
    output logic            overflow,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] LAST_ITER = (SHW+1)'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] OP_AND    = 5'h00;
    localparam logic [4:0] OP_OR     = 5'h01;
    localparam logic [4:0] OP_ADD    = 5'h02;
    localparam logic [4:0] OP_XOR    = 5'h03;
    localparam logic [4:0] OP_SLL    = 5'h04;
    localparam logic [4:0] OP_SRL    = 5'h05;
    localparam logic [4:0] OP_SUB    = 5'h06;
    localparam logic [4:0] OP_SRA    = 5'h07;
    localparam logic [4:0] OP_SLT    = 5'h08;
    localparam logic [4:0] OP_SLTU   = 5'h09;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHU  = 5'h13;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state, state_nxt;
    logic [SHW:0]        count;
    logic [4:0]          op_q;
    logic [XLEN-1:0]     opa, opb, quo, rem_r;
    logic [2*XLEN-1:0]   prod;
    logic                neg_ab, neg_a;

    logic                accept, is_mul, is_div, div_signed, div_zero, div_ovf, last_iter;
    logic                a_sgn, b_sgn;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [XLEN:0]       sum, diff;
    logic [SHW-1:0]      shamt;
    logic [XLEN-1:0]     imm_rd;
    logic                imm_c, imm_v;

    logic [XLEN:0]       mul_sum, r_shift;
    logic [2*XLEN-1:0]   prod_step, prod_fin;
    logic                div_ge;
    logic [XLEN-1:0]     quo_step, rem_step, q_fin, r_fin, mul_rd, div_rd;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state == MUL) || (state == DIV);
    assign accept     = in_valid && in_ready && !kill;
    assign is_mul     = (op[4:2] == 3'b100);
    assign is_div     = (op[4:2] == 3'b101);
    assign div_signed = !op[0];
    assign div_zero   = (rs2 == '0);
    assign div_ovf    = div_signed && (rs1 == MOST_NEG) && (rs2 == '1);
    assign last_iter  = (count == LAST_ITER);

    // Operand magnitudes; sign handling is reapplied to the final result.
    assign a_sgn = rs1[XLEN-1] && (is_mul ? (op != OP_MULHU) : div_signed);
    assign b_sgn = rs2[XLEN-1] && (is_mul ? ((op == OP_MUL) || (op == OP_MULH)) : div_signed);
    assign mag_a = a_sgn ? -rs1 : rs1;
    assign mag_b = b_sgn ? -rs2 : rs2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul)
                        state_nxt = MUL;
                    else if (is_div && !div_zero && !div_ovf)
                        state_nxt = DIV;
                    else
                        state_nxt = DONE;
                end
            end
            MUL, DIV: begin
                if (kill)
                    state_nxt = IDLE;
                else if (last_iter)
                    state_nxt = DONE;
            end
            DONE: begin
                if (kill || out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle results: base ops, invalid codes and the divide special cases.
    always_comb begin
        sum    = {1'b0, rs1} + {1'b0, rs2};
        diff   = {1'b0, rs1} - {1'b0, rs2};
        shamt  = rs2[SHW-1:0];
        imm_rd = '0;
        imm_c  = 1'b0;
        imm_v  = 1'b0;
        if (is_div) begin
            if (div_zero)
                imm_rd = op[1] ? rs1 : '1;
            else begin
                imm_rd = op[1] ? '0 : MOST_NEG;
                imm_v  = 1'b1;
            end
        end else begin
            case (op)
                OP_AND:  imm_rd = rs1 & rs2;
                OP_OR:   imm_rd = rs1 | rs2;
                OP_XOR:  imm_rd = rs1 ^ rs2;
                OP_ADD: begin
                    imm_rd = sum[XLEN-1:0];
                    imm_c  = sum[XLEN];
                    imm_v  = (rs1[XLEN-1] == rs2[XLEN-1]) && (sum[XLEN-1] != rs1[XLEN-1]);
                end
                OP_SUB: begin
                    imm_rd = diff[XLEN-1:0];
                    imm_c  = diff[XLEN];
                    imm_v  = (rs1[XLEN-1] != rs2[XLEN-1]) && (diff[XLEN-1] != rs1[XLEN-1]);
                end
                OP_SLL:  imm_rd = rs1 << shamt;
                OP_SRL:  imm_rd = rs1 >> shamt;
                OP_SRA:  imm_rd = $signed(rs1) >>> shamt;
                OP_SLT:  imm_rd = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
                OP_SLTU: imm_rd = {{(XLEN-1){1'b0}}, rs1 < rs2};
                default: imm_rd = '0;
            endcase
        end
    end

    // One shift-add multiply step and one restoring divide step per cycle.
    always_comb begin
        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opa} : '0);
        prod_step = {mul_sum, prod[XLEN-1:1]};
        prod_fin  = neg_ab ? -prod_step : prod_step;
        mul_rd    = (op_q[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];

        r_shift   = {rem_r, quo[XLEN-1]};
        div_ge    = (r_shift >= {1'b0, opb});
        rem_step  = div_ge ? XLEN'(r_shift - {1'b0, opb}) : r_shift[XLEN-1:0];
        quo_step  = {quo[XLEN-2:0], div_ge};
        q_fin     = neg_ab ? -quo_step : quo_step;
        r_fin     = neg_a ? -rem_step : rem_step;
        div_rd    = op_q[1] ? r_fin : q_fin;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            op_q     <= '0;
            opa      <= '0;
            opb      <= '0;
            quo      <= '0;
            rem_r    <= '0;
            prod     <= '0;
            neg_ab   <= 1'b0;
            neg_a    <= 1'b0;
            rd       <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            count    <= '0;
            op_q     <= op;
            opa      <= mag_a;
            opb      <= mag_b;
            quo      <= mag_a;
            rem_r    <= '0;
            prod     <= {{XLEN{1'b0}}, mag_b};
            neg_ab   <= a_sgn ^ b_sgn;
            neg_a    <= a_sgn;
            if (!is_mul && !(is_div && !div_zero && !div_ovf)) begin
                rd       <= imm_rd;
                zero     <= (imm_rd == '0);
                carry    <= imm_c;
                overflow <= imm_v;
            end
        end else if (state == MUL && !kill) begin
            prod  <= prod_step;
            count <= count + {{SHW{1'b0}}, 1'b1};
            if (last_iter) begin
                rd       <= mul_rd;
                zero     <= (mul_rd == '0);
                carry    <= 1'b0;
                overflow <= 1'b0;
            end
        end else if (state == DIV && !kill) begin
            quo   <= quo_step;
            rem_r <= rem_step;
            count <= count + {{SHW{1'b0}}, 1'b1};
            if (last_iter) begin
                rd       <= div_rd;
                zero     <= (div_rd == '0);
                carry    <= 1'b0;
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Directed-vector bench for alu_md (XLEN=64) with immediate-assertion checks.
module tb_alu_md;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, kill, out_valid, out_ready;
    logic        zero, carry, overflow, busy;
    logic [4:0]  op;
    logic [63:0] rs1, rs2, rd;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        seen_valid;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MNEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MPOS = 64'h7FFF_FFFF_FFFF_FFFF;

    always #5 clk = ~clk;

    alu_md #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .rd(rd), .zero(zero), .carry(carry),
        .overflow(overflow), .busy(busy)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b);
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_output(input string tag, input logic [63:0] exp_rd, input logic [2:0] exp_zcv);
        check_val({tag, "/rd"}, rd, exp_rd);
        check_val({tag, "/zcv"}, {61'd0, zero, carry, overflow}, {61'd0, exp_zcv});
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "/idle"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [4:0] o, input logic [63:0] a,
                          input logic [63:0] b, input int lat, input logic [63:0] exp_rd,
                          input logic [2:0] exp_zcv);
        apply_stimulus(o, a, b);
        wait_result(tag, lat);
        check_output(tag, exp_rd, exp_zcv);
        release_result(tag);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        op = '0; rs1 = '0; rs2 = '0;
        #2;
        check_output("reset", 64'd0, 3'b000);
        check_val("reset/ctrl", {61'd0, out_valid, busy, in_ready}, 64'd1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        run_op("add_ovf",   5'h02, MPOS, 64'd1, 1, MNEG, 3'b001);
        run_op("add_carry", 5'h02, ALL1, 64'd1, 1, 64'd0, 3'b110);
        run_op("sub_borrow",5'h06, 64'd1, 64'd2, 1, ALL1, 3'b010);
        run_op("sub_ovf",   5'h06, MNEG, 64'd1, 1, MPOS, 3'b001);
        run_op("and",       5'h00, 64'hF0F0, 64'h0FF0, 1, 64'h00F0, 3'b000);
        run_op("or",        5'h01, 64'hF0F0, 64'h0F0F, 1, 64'hFFFF, 3'b000);
        run_op("xor",       5'h03, 64'hF0F0, 64'hFF00, 1, 64'h0FF0, 3'b000);
        run_op("sll",       5'h04, 64'd1, 64'h41, 1, 64'd2, 3'b000);
        run_op("srl",       5'h05, MNEG, 64'd4, 1, 64'h0800_0000_0000_0000, 3'b000);
        run_op("sra",       5'h07, MNEG, 64'd4, 1, 64'hF800_0000_0000_0000, 3'b000);
        run_op("sltu",      5'h09, 64'd1, ALL1, 1, 64'd1, 3'b000);
        run_op("slt",       5'h08, 64'd1, ALL1, 1, 64'd0, 3'b100);
        run_op("bad_0a",    5'h0A, 64'd5, 64'd3, 1, 64'd0, 3'b100);
        run_op("bad_1f",    5'h1F, ALL1, ALL1, 1, 64'd0, 3'b100);

        run_op("mulhu",     5'h13, ALL1, ALL1, 65, 64'hFFFF_FFFF_FFFF_FFFE, 3'b000);
        run_op("mul",       5'h10, ALL1, ALL1, 65, 64'd1, 3'b000);
        run_op("mulh",      5'h11, MNEG, MNEG, 65, 64'h4000_0000_0000_0000, 3'b000);
        run_op("mulhsu",    5'h12, ALL1, ALL1, 65, ALL1, 3'b000);
        run_op("div",       5'h14, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, 3'b000);
        run_op("rem",       5'h16, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, ALL1, 3'b000);
        run_op("divu",      5'h15, 64'd100, 64'd7, 65, 64'd14, 3'b000);
        run_op("remu",      5'h17, 64'd100, 64'd7, 65, 64'd2, 3'b000);
        run_op("divu_by0",  5'h15, 64'd5, 64'd0, 1, ALL1, 3'b000);
        run_op("remu_by0",  5'h17, 64'd5, 64'd0, 1, 64'd5, 3'b000);
        run_op("div_ovf",   5'h14, MNEG, ALL1, 1, MNEG, 3'b001);
        run_op("rem_ovf",   5'h16, MNEG, ALL1, 1, 64'd0, 3'b101);

        // Result held in DONE while the consumer stalls; new requests ignored.
        apply_stimulus(5'h02, ALL1, 64'd8);
        wait_result("hold", 1);
        op = 5'h02; rs1 = 64'd10; rs2 = 64'd10; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_output("hold", 64'd7, 3'b010);
            check_val("hold/ctrl", {62'd0, out_valid, in_ready}, 64'd2);
        end
        in_valid = 1'b0;
        release_result("hold");

        // Kill in the middle of a divide drops the result.
        apply_stimulus(5'h15, 64'd100, 64'd7);
        repeat (19) begin @(posedge clk); #1; end
        check_val("kill_div/busy", {63'd0, busy}, 64'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check_val("kill_div/ctrl", {61'd0, out_valid, in_ready, busy}, 64'd2);
        seen_valid = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | out_valid;
        end
        check_val("kill_div/no_valid", {63'd0, seen_valid}, 64'd0);

        // Kill while idle blocks acceptance.
        op = 5'h02; rs1 = 64'd1; rs2 = 64'd1; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        check_val("kill_idle/ctrl", {61'd0, out_valid, in_ready, busy}, 64'd2);
        @(posedge clk); #1;
        check_val("kill_idle/later", {61'd0, out_valid, in_ready, busy}, 64'd2);

        // Asynchronous reset mid-multiply, between clock edges.
        apply_stimulus(5'h10, 64'd3, 64'd5);
        repeat (29) begin @(posedge clk); #1; end
        check_val("rst_mul/busy", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check_output("rst_mul", 64'd0, 3'b000);
        check_val("rst_mul/ctrl", {61'd0, out_valid, busy, in_ready}, 64'd1);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        run_op("slt_after_rst", 5'h08, ALL1, 64'd0, 1, 64'd1, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter XLEN, default 64: operand/result width; legal values 32 and 64.
REQ-002 SHALL have localparam SHW = log2(XLEN): shift-amount width, 6 for XLEN=64.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  5  operation code (REQ-015).
REQ-008 SHALL have ports rs1, rs2  input  XLEN  signed operands.
REQ-009 SHALL have port kill  input  1  synchronous abort of the in-flight operation.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port rd  output  XLEN  registered result.
REQ-013 SHALL have ports zero, carry, overflow  output  1 each  registered flags.
REQ-014 SHALL have port busy  output  1  high in MUL or DIV state.

Function
REQ-015 Op codes SHALL be: 0x00 AND, 0x01 OR, 0x02 ADD, 0x03 XOR, 0x04 SLL, 0x05 SRL, 0x06 SUB, 0x07 SRA, 0x08 SLT, 0x09 SLTU, 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU, 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
REQ-016 Any other op SHALL complete as a base op with rd=0, carry=0, overflow=0, zero=1.
REQ-017 The FSM SHALL have states IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-018 A request SHALL be accepted when in_valid && in_ready; op and operands are captured that cycle.
REQ-019 Base ops (0x00-0x09, invalid codes) SHALL go IDLE->DONE, result valid the cycle after acceptance.
REQ-020 Shifts SHALL use rs2[SHW-1:0] only; SRA replicates rs1[XLEN-1]; SLT/SLTU return 1 or 0.
REQ-021 ADD/SUB SHALL set carry = unsigned carry-out (SUB: borrow, rs1 <u rs2) and overflow = signed overflow; all other ops drive carry=0.
REQ-022 Multiplies SHALL use iterative shift-add, one bit per cycle, staying in MUL exactly XLEN cycles, then DONE; MUL returns low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned operands.
REQ-023 Divides SHALL use restoring division on magnitudes, staying in DIV exactly XLEN cycles, then DONE; signed quotient truncates toward zero; remainder sign follows rs1.
REQ-024 Divide by zero SHALL skip DIV (IDLE->DONE): quotient all-ones, remainder = rs1, overflow=0.
REQ-025 Signed DIV/REM of most-negative value by -1 SHALL skip DIV: quotient = most-negative value, remainder 0, overflow=1.
REQ-026 zero SHALL equal (rd==0) for every op.
REQ-027 In DONE, rd and flags SHALL hold stable until out_ready=1, then go to IDLE next cycle.
REQ-028 in_valid SHALL be ignored while in_ready=0; no queuing.
REQ-029 kill=1 in MUL, DIV or DONE SHALL force IDLE next cycle, out_valid=0, result dropped; kill in IDLE SHALL block acceptance that cycle.
REQ-030 The iteration counter SHALL be log2(XLEN)+1 bits and SHALL clear on every acceptance.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE, rd=0, zero=0, carry=0, overflow=0, out_valid=0, busy=0, counter=0, regardless of clk.
REQ-032 Reset asserted mid MUL/DIV SHALL discard the operation; first acceptance after release behaves as from power-up.

Verification (XLEN=64)
REQ-033 ADD rs1=0x7FFFFFFFFFFFFFFF, rs2=1 -> one cycle later out_valid=1, rd=0x8000000000000000, overflow=1, carry=0, zero=0.
REQ-034 MULHU rs1=rs2=0xFFFFFFFFFFFFFFFF -> out_valid exactly 65 cycles after acceptance, rd=0xFFFFFFFFFFFFFFFE; MUL same operands -> rd=1.
REQ-035 DIV rs1=-7, rs2=2 -> rd=-3 after 65 cycles; REM same -> rd=-1; DIVU rs1=5, rs2=0 -> rd=all-ones after 1 cycle; REMU same -> rd=5.
REQ-036 DIV rs1=0x8000000000000000, rs2=-1 -> 1 cycle, rd=0x8000000000000000, overflow=1; REM same -> rd=0, zero=1.
REQ-037 out_ready held low 10 cycles in DONE -> rd/flags constant, in_ready=0, in_valid ignored; kill at cycle 20 of DIV -> IDLE next cycle, no out_valid.
REQ-038 reset pulse at cycle 30 of MUL, no clk edge -> outputs zero immediately; next SLT rs1=-1, rs2=0 -> rd=1.
